// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci XNOR LFSR pattern generator with seed loading,
// a run-length sequencer (IDLE/RUNNING/COMPLETE), stall and lockup protection.
module lfsr_gen #(
  parameter int unsigned      WIDTH = 20,
  parameter logic [WIDTH-1:0] TAPS  = 20'h80040,
  parameter logic [WIDTH-1:0] SEED  = 20'h00101,
  parameter int unsigned      CNT_W = 16
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             start,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [CNT_W-1:0] run_len,
  input  logic             stall,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             done,
  output logic             lockup
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_COMPLETE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic             valid_q, valid_d;
  logic             lockup_q, lockup_d;
  logic             fb;

  assign fb = ~^(data_q & TAPS);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= ST_IDLE;
      data_q    <= SEED;
      count_q   <= '0;
      run_len_q <= '0;
      valid_q   <= 1'b0;
      lockup_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      count_q   <= count_d;
      run_len_q <= run_len_d;
      valid_q   <= valid_d;
      lockup_q  <= lockup_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    count_d   = count_q;
    run_len_d = run_len_q;
    valid_d   = 1'b0;
    lockup_d  = lockup_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUNNING;
          count_d   = '0;
          run_len_d = run_len;
          lockup_d  = 1'b0;
        end
        // All-ones would freeze an XNOR LFSR, so it is swapped for SEED.
        if (load) begin
          if (seed_in == '1) begin
            data_d   = SEED;
            lockup_d = 1'b1;
          end else begin
            data_d = seed_in;
          end
        end
      end

      ST_RUNNING: begin
        if (!stall) begin
          data_d  = {data_q[WIDTH-2:0], fb};
          count_d = count_q + CNT_W'(1);
          valid_d = 1'b1;
          if ((run_len_q != '0) && (count_d == run_len_q)) begin
            state_d = ST_COMPLETE;
          end
        end
      end

      ST_COMPLETE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign busy       = (state_q == ST_RUNNING);
  assign done       = (state_q == ST_COMPLETE);
  assign lockup     = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed self-checking bench for lfsr_gen: a vector table for the
// sequencer/lockup behaviour plus hand-written stall, reset and 4-bit runs.
module tb_lfsr_gen;

  logic        clk;
  logic        nreset;
  logic        start;
  logic        load;
  logic [19:0] seed_in;
  logic [15:0] run_len;
  logic        stall;
  logic [19:0] data_out;
  logic        data_valid;
  logic        busy;
  logic        done;
  logic        lockup;

  logic        s4_start;
  logic        s4_load;
  logic [3:0]  s4_seed_in;
  logic [15:0] s4_run_len;
  logic        s4_stall;
  logic [3:0]  s4_data_out;
  logic        s4_data_valid;
  logic        s4_busy;
  logic        s4_done;
  logic        s4_lockup;

  int checks_total;
  int checks_passed;

  lfsr_gen u_dut (
    .clk        (clk),
    .nreset     (nreset),
    .start      (start),
    .load       (load),
    .seed_in    (seed_in),
    .run_len    (run_len),
    .stall      (stall),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .done       (done),
    .lockup     (lockup)
  );

  lfsr_gen #(
    .WIDTH (4),
    .TAPS  (4'hC),
    .SEED  (4'h1),
    .CNT_W (16)
  ) u_dut4 (
    .clk        (clk),
    .nreset     (nreset),
    .start      (s4_start),
    .load       (s4_load),
    .seed_in    (s4_seed_in),
    .run_len    (s4_run_len),
    .stall      (s4_stall),
    .data_out   (s4_data_out),
    .data_valid (s4_data_valid),
    .busy       (s4_busy),
    .done       (s4_done),
    .lockup     (s4_lockup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        load;
    logic [19:0] seed;
    logic [15:0] run_len;
    logic        stall;
    logic [19:0] e_data;
    logic        e_valid;
    logic        e_busy;
    logic        e_done;
    logic        e_lock;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [0:NVEC-1];

  // Reference model of the default 20-bit generator (taps 19 and 6, XNOR).
  function automatic logic [19:0] next_val(input logic [19:0] d);
    return {d[18:0], ~^(d & 20'h80040)};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start   = 1'b0;
    load    = 1'b0;
    seed_in = 20'h0;
    run_len = 16'd0;
    stall   = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    idle_inputs();
    nreset = 1'b0;
    #3;
    nreset = 1'b1;
  endtask

  task automatic check_all(input string tag, input logic [19:0] e_data, input logic e_valid,
                           input logic e_busy, input logic e_done, input logic e_lock);
    check_output({tag, ".data"},   32'(data_out),   32'(e_data));
    check_output({tag, ".valid"},  32'(data_valid), 32'(e_valid));
    check_output({tag, ".busy"},   32'(busy),       32'(e_busy));
    check_output({tag, ".done"},   32'(done),       32'(e_done));
    check_output({tag, ".lockup"}, 32'(lockup),     32'(e_lock));
  endtask

  initial begin
    logic [19:0] model;
    logic [3:0]  exp4 [0:14];

    checks_total  = 0;
    checks_passed = 0;
    nreset        = 1'b0;
    idle_inputs();
    s4_start   = 1'b0;
    s4_load    = 1'b0;
    s4_seed_in = 4'h0;
    s4_run_len = 16'd0;
    s4_stall   = 1'b0;

    //            start load  seed      run_len stall  data      vld   busy  done  lock
    vecs[0]  = '{1'b1, 1'b0, 20'h0,     16'd3, 1'b0, 20'h00101, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 20'h0,     16'd0, 1'b0, 20'h00203, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 20'hFFFFF, 16'd0, 1'b0, 20'h00407, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 20'h0,     16'd5, 1'b0, 20'h0080F, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 20'hFFFFF, 16'd5, 1'b0, 20'h0080F, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 20'hFFFFF, 16'd0, 1'b0, 20'h00101, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 20'h0,     16'd0, 1'b0, 20'h00101, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 20'h0,     16'd1, 1'b0, 20'h00101, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 20'h0,     16'd0, 1'b0, 20'h00203, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 20'h0,     16'd0, 1'b0, 20'h00203, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 20'h00001, 16'd2, 1'b0, 20'h00001, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 20'h0,     16'd0, 1'b0, 20'h00003, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 20'h0,     16'd0, 1'b0, 20'h00007, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 20'h0,     16'd0, 1'b0, 20'h00007, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 20'hFFFFF, 16'd1, 1'b0, 20'h00101, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 20'h0,     16'd0, 1'b1, 20'h00101, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 20'h0,     16'd0, 1'b0, 20'h00203, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 20'h0,     16'd0, 1'b0, 20'h00203, 1'b0, 1'b0, 1'b0, 1'b1};

    exp4[0]  = 4'h3; exp4[1]  = 4'h7; exp4[2]  = 4'hE; exp4[3]  = 4'hD; exp4[4]  = 4'hB;
    exp4[5]  = 4'h6; exp4[6]  = 4'hC; exp4[7]  = 4'h9; exp4[8]  = 4'h2; exp4[9]  = 4'h5;
    exp4[10] = 4'hA; exp4[11] = 4'h4; exp4[12] = 4'h8; exp4[13] = 4'h0; exp4[14] = 4'h1;

    #12;
    check_all("reset", 20'h00101, 1'b0, 1'b0, 1'b0, 1'b0);
    nreset = 1'b1;

    $display("[TB] vector table");
    for (int i = 0; i < NVEC; i++) begin
      start   = vecs[i].start;
      load    = vecs[i].load;
      seed_in = vecs[i].seed;
      run_len = vecs[i].run_len;
      stall   = vecs[i].stall;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_valid,
                vecs[i].e_busy, vecs[i].e_done, vecs[i].e_lock);
    end

    $display("[TB] free-run with alternating stall");
    do_reset();
    model   = 20'h00101;
    start   = 1'b1;
    run_len = 16'd0;
    step();
    idle_inputs();
    check_all("fr_start", model, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      stall = i[0];
      step();
      if (!stall) model = next_val(model);
      check_all($sformatf("fr%0d", i), model, ~stall, 1'b1, 1'b0, 1'b0);
    end

    $display("[TB] reset mid-run");
    do_reset();
    model   = 20'h00101;
    start   = 1'b1;
    run_len = 16'd10;
    step();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      step();
      model = next_val(model);
    end
    check_all("mid_shift5", model, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    nreset = 1'b0;
    #1;
    check_all("mid_async", 20'h00101, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    nreset = 1'b1;
    step();
    check_all("mid_after", 20'h00101, 1'b0, 1'b0, 1'b0, 1'b0);
    start   = 1'b1;
    run_len = 16'd1;
    step();
    idle_inputs();
    check_all("mid_restart", 20'h00101, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_all("mid_shift1", 20'h00203, 1'b1, 1'b0, 1'b1, 1'b0);

    $display("[TB] 4-bit maximal-length run");
    do_reset();
    check_output("w4.reset", 32'(s4_data_out), 32'h1);
    s4_start   = 1'b1;
    s4_run_len = 16'd15;
    step();
    s4_start   = 1'b0;
    s4_run_len = 16'd0;
    check_output("w4.busy", 32'(s4_busy), 32'h1);
    for (int i = 0; i < 15; i++) begin
      step();
      check_output($sformatf("w4.data%0d", i), 32'(s4_data_out), 32'(exp4[i]));
      check_output($sformatf("w4.done%0d", i), 32'(s4_done), (i == 14) ? 32'h1 : 32'h0);
    end
    step();
    check_output("w4.idle_busy", 32'(s4_busy), 32'h0);
    check_output("w4.idle_done", 32'(s4_done), 32'h0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
